// File: rtl/rr_encoder_4x2_pkg.sv
// Shared constants for the round-robin request encoder.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package rr_encoder_4x2_pkg;

    localparam int ENC_N = 4;
    localparam int ENC_W = 2;

    // The top level keeps the IDLE/HOLD state in out_valid itself.
    // This enum gives the two states names for anyone decoding that flag.
    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_HOLD = 1'b1
    } enc_state_e;

endpackage

// File: rtl/rr_encoder_4x2_pick.sv
// Round-robin selector: finds the first set bit of pend_i, scanning from ptr_i upward mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
// Ports: pend_i (candidate set), ptr_i (scan start) -> found_o (any bit set), sel_o (winning index).
module rr_pick
    import rr_encoder_4x2_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic [N-1:0] pend_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] sel_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    // Shifting the doubled vector right by ptr_i rotates the request set.
    // After the shift, bit 0 is the request at index ptr_i.
    assign dbl = {pend_i, pend_i} >> ptr_i;
    assign rot = dbl[N-1:0];

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        found_o = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = i[W-1:0];
            end
        end
    end

    // N is a power of two, so the W-bit add wraps mod N for free.
    assign sel_o = ptr_i + off;

endmodule

// File: rtl/rr_encoder_4x2.sv
// Round-robin encoder: latches requests into a pending set and emits one binary index per handshake.
// Latency: a req sampled at edge t can appear at edge t+1 if idle; one code per cycle while out_ready=1.
// Backpressure: out_ready=0 holds out_code/out_valid; pending keeps accumulating requests.
// Ports: clk, rst_n (async active-low), req (request lines), out_code/out_valid/out_ready (output handshake),
//        pending (latched requests not yet emitted, status only).
module rr_encoder_4x2
    import rr_encoder_4x2_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q;
    logic [W-1:0] out_code_q;
    logic         out_valid_q;

    logic         found;
    logic [W-1:0] sel;
    logic         advance;
    logic         grant;
    logic [N-1:0] clear_mask;

    // The selector sees only the registered pending set, never raw req.
    rr_pick #(.N(N), .W(W)) u_pick (
        .pend_i  (pending_q),
        .ptr_i   (ptr_q),
        .found_o (found),
        .sel_o   (sel)
    );

    // A new code may be loaded when idle, or when the current one is accepted.
    assign advance = ~out_valid_q | out_ready;
    assign grant   = advance & found;

    // The granted bit leaves pending as it is loaded into out_code.
    // OR-ing req afterwards lets a same-cycle re-request win over the clear.
    always_comb begin
        clear_mask = '0;
        if (grant) begin
            clear_mask = {{(N-1){1'b0}}, 1'b1} << sel;
        end
        pending_d = (pending_q & ~clear_mask) | req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            ptr_q       <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (grant) begin
                out_code_q  <= sel;
                out_valid_q <= 1'b1;
                ptr_q       <= sel + W'(1);
            end else if (advance) begin
                // Handshake with nothing left to send: drop to idle, keep the last code.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_rr_encoder_4x2.sv
// Directed testbench for rr_encoder_4x2.
// Inputs are driven and outputs are sampled on the falling edge; the DUT is clocked on the rising edge.
// Each comparison checks {out_valid, out_code, pending} against a hand-computed value.
module tb_rr_encoder_4x2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;

    int checks;
    int errors;

    rr_encoder_4x2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        exp = 7'b0_00_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_code, pending} !== exp) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b required %b", i, {out_valid, out_code, pending}, exp);
            end
        end
        rst_n = 1'b1;
        // First edge only captures the requests.
        @(negedge clk);
        exp = 7'b0_00_1111;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL reset_first_edge: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        // Second edge presents code 0; req still held so pending stays full.
        @(negedge clk);
        req = 4'b0000;
        exp = 7'b1_00_1111;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL reset_first_code: got %b required %b", {out_valid, out_code, pending}, exp);
        end
    endtask

    task automatic test_single();
        logic [6:0] exp;
        apply_reset();
        req       = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        exp = 7'b0_00_0100;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL single_capture: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        @(negedge clk);
        exp = 7'b1_10_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL single_code: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        @(negedge clk);
        exp = 7'b0_10_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL single_idle: got %b required %b", {out_valid, out_code, pending}, exp);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_first_edge: got valid %b required 0", out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_code} !== {1'b1, seq[i]}) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got %b required %b", i, {out_valid, out_code}, {1'b1, seq[i]});
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [6:0] exp;
        apply_reset();
        req       = 4'b1010;
        out_ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        exp = 7'b1_01_1000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_code, pending} !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %b required %b", i, {out_valid, out_code, pending}, exp);
            end
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp = 7'b1_11_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL bp_second: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        @(negedge clk);
        exp = 7'b0_11_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL bp_drain: got %b required %b", {out_valid, out_code, pending}, exp);
        end
    endtask

    task automatic test_collision();
        logic [6:0] exp;
        logic [1:0] seq [3];
        seq = '{2'd0, 2'd1, 2'd2};
        apply_reset();
        req       = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        exp = 7'b1_10_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL col_present: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        // Queue other requests while code 2 is stalled.
        req = 4'b1011;
        @(negedge clk);
        exp = 7'b1_10_1011;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL col_queue: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        // Handshake while re-requesting bit 2; next pick starts at index 3.
        req       = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        exp = 7'b1_11_0111;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL col_requeue: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_code} !== {1'b1, seq[i]}) begin
                errors++;
                $display("FAIL col_seq[%0d]: got %b required %b", i, {out_valid, out_code}, {1'b1, seq[i]});
            end
        end
        @(negedge clk);
        exp = 7'b0_10_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL col_drain: got %b required %b", {out_valid, out_code, pending}, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] exp;
        apply_reset();
        req       = 4'b1000;
        out_ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        exp = 7'b1_11_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL midrst_hold: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        // Pulse reset between edges; outputs must clear without waiting for a clock.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp = 7'b0_00_0000;
        checks++;
        if ({out_valid, out_code, pending} !== exp) begin
            errors++;
            $display("FAIL midrst_async: got %b required %b", {out_valid, out_code, pending}, exp);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_code, pending} !== exp) begin
                errors++;
                $display("FAIL midrst_after[%0d]: got %b required %b", i, {out_valid, out_code, pending}, exp);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
